mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multi-cycle MULT/MULTU/DIV/DIVU engine. Produces the HI/LO results and write
//  enables consumed by the HI/LO register file, one bit per enabled cycle.
//  Sits in the execute stage. The control unit issues one operation and stalls on busy.
//  The busy output is also used to stall MFHI/MFLO.
// PARAMETERS
//  DATA_WIDTH  32  operand and result-half width; latency scales with it
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  clk_enable       in   1   global enable; when low, all state freezes
//  start            in   1   issue request, sampled on an enabled edge while idle
//  op               in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  rs_data          in   32  multiplicand / dividend
//  rt_data          in   32  multiplier / divisor
//  busy             out  1   operation in progress (RUN or DONE state)
//  HI_input         out  32  HI result (product[63:32] / remainder)
//  LO_input         out  32  LO result (product[31:0] / quotient)
//  HI_write_enable  out  1   one-cycle write strobe to HI
//  LO_write_enable  out  1   one-cycle write strobe to LO
// BEHAVIOUR
//  Reset
//   - Asynchronous and immediate: state = IDLE, counter = 0.
//   - busy = 0, both write enables = 0, HI_input = LO_input = 0.
//   - An operation in flight is discarded; no write strobe is ever produced for it.
//  Cycle counting
//   - Only edges with clk_enable = 1 count. With clk_enable = 0, state, counter,
//     datapath and outputs all hold.
//   - A write strobe therefore stays high while frozen in DONE. This is safe because
//     the register file is gated by the same enable.
//  FSM
//   - IDLE -> RUN: on an enabled edge with start = 1.
//       Operands are captured, absolute values are taken for signed ops,
//       result signs are recorded, and counter = 0.
//   - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per
//       enabled edge; counter increments.
//   - RUN -> DONE: on the DATA_WIDTH-th step.
//       Sign fix-up is applied and the results are registered into HI_input/LO_input.
//   - DONE -> IDLE: on the next enabled edge unconditionally.
//  Latency
//   - Start edge E0 -> results valid and strobes high after edge E(DATA_WIDTH),
//     i.e. E32 by default.
//   - Strobes are high for exactly one enabled cycle.
//  Handshake
//   - busy is high from after E0 until after the DONE->IDLE edge.
//   - start while busy (RUN or DONE) is ignored; operands are not re-captured.
//   - start in the same cycle DONE->IDLE occurs is also ignored. Re-issue is accepted
//     from IDLE only.
//  Write enables
//   - HI_write_enable = LO_write_enable = (state == DONE), registered, not glitching.
//     Both are always asserted together.
//  Arithmetic
//   - MULTU: {HI,LO} = rs * rt, 64-bit unsigned.
//   - MULT: the unsigned product of |rs|,|rt|, negated (two's complement, 64-bit) if
//     the operand signs differ.
//   - DIVU: LO = rs / rt, HI = rs % rt.
//   - DIV: the quotient is negated if the signs differ; the remainder takes the sign
//     of rs; |remainder| < |rt|.
//   - Edge: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
//   - Divide by zero (either signedness): HI = rs_data as captured, LO = 0xFFFFFFFF.
//     Same latency; no exception.
//  Results
//   - HI_input/LO_input hold the last result after DONE until the next DONE or reset.
// TESTING
//  1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> at E32 HI=0xFFFFFFFE, LO=0x00000001; strobes
//     high for exactly 1 cycle; busy low after E33.
//  2. MULT -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//     MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
//  3. DIVU 7/2 -> LO=3, HI=1. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
//  4. DIV 0x1234/0 -> HI=0x00001234, LO=0xFFFFFFFF at E32.
//     DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5. Second start with new operands at E5 -> ignored; the first result is unchanged.
//     clk_enable low for 5 cycles mid-RUN -> strobe delayed by exactly 5 cycles,
//     result unchanged.
//  6. reset pulsed asynchronously (between edges) at cycle 10 of an op -> busy,
//     strobes and HI/LO outputs 0 immediately; no strobe ever follows.
//     A new MULTU 6*7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine, one shift-add or
// restoring shift-subtract step per enabled cycle, HI/LO write strobes on completion.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] HI_input,
    output logic [DATA_WIDTH-1:0] LO_input,
    output logic                  HI_write_enable,
    output logic                  LO_write_enable
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic [W-1:0]    mcand;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    rs_raw;
    logic            write_en;

    logic            a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      add_sum, shifted, diff;
    logic [W-1:0]    next_hi, next_lo;
    logic [2*W-1:0]  prod, prod_fixed;
    logic [W-1:0]    quo_fixed, rem_fixed;
    logic [W-1:0]    final_hi, final_lo;

    always_comb begin
        a_neg = op[0] & rs_data[W-1];
        b_neg = op[0] & rt_data[W-1];
        abs_a = a_neg ? (~rs_data + 1'b1) : rs_data;
        abs_b = b_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // hi/lo hold {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        add_sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {W{1'b0}})};
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, mcand};
        if (is_div) begin
            if (!diff[W]) begin
                next_hi = diff[W-1:0];
                next_lo = {lo[W-2:0], 1'b1};
            end else begin
                next_hi = shifted[W-1:0];
                next_lo = {lo[W-2:0], 1'b0};
            end
        end else begin
            next_hi = add_sum[W:1];
            next_lo = {add_sum[0], lo[W-1:1]};
        end
    end

    always_comb begin
        prod       = {next_hi, next_lo};
        prod_fixed = neg_q ? (~prod + 1'b1) : prod;
        quo_fixed  = neg_q ? (~next_lo + 1'b1) : next_lo;
        rem_fixed  = neg_r ? (~next_hi + 1'b1) : next_hi;
        if (!is_div) begin
            final_hi = prod_fixed[2*W-1:W];
            final_lo = prod_fixed[W-1:0];
        end else if (div_zero) begin
            final_hi = rs_raw;
            final_lo = {W{1'b1}};
        end else begin
            final_hi = rem_fixed;
            final_lo = quo_fixed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            rs_raw   <= '0;
            busy     <= 1'b0;
            write_en <= 1'b0;
            HI_input <= '0;
            LO_input <= '0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        counter  <= '0;
                        busy     <= 1'b1;
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= op[1] & (rt_data == '0);
                        rs_raw   <= rs_data;
                        hi       <= '0;
                        mcand    <= op[1] ? abs_b : abs_a;
                        lo       <= op[1] ? abs_a : abs_b;
                    end
                end
                RUN: begin
                    hi      <= next_hi;
                    lo      <= next_lo;
                    counter <= counter + 1'b1;
                    if (counter == CW'(W - 1)) begin
                        state    <= DONE;
                        write_en <= 1'b1;
                        HI_input <= final_hi;
                        LO_input <= final_lo;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    write_en <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    write_en <= 1'b0;
                end
            endcase
        end
    end

    assign HI_write_enable = write_en;
    assign LO_write_enable = write_en;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: directed scoreboard bench for the iterative multiply/divide engine.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] HI_input;
    logic [31:0] LO_input;
    logic        HI_write_enable;
    logic        LO_write_enable;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .HI_input(HI_input),
        .LO_input(LO_input), .HI_write_enable(HI_write_enable),
        .LO_write_enable(LO_write_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} built from native SystemVerilog arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        int     ia, ib, q, r;
        logic [63:0] res;
        case (o)
            2'd0: res = {32'b0, a} * {32'b0, b};
            2'd1: begin
                sa  = longint'($signed(a));
                sb2 = longint'($signed(b));
                res = 64'(sa * sb2);
            end
            2'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    q  = ia / ib;
                    r  = ia % ib;
                    res = {32'(r), 32'(q)};
                end
            end
        endcase
        return res;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) sb.push_back(model(o, a, b));
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_result(input string tag, input int lat);
        int n = 0;
        bit seen = 0;
        logic [63:0] exp;
        for (int i = 0; i < lat + 20 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (HI_write_enable) seen = 1;
        end
        check({tag, "_strobe"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(n), 64'(lat));
            check({tag, "_lo_we"}, 64'(LO_write_enable), 64'd1);
            check({tag, "_busy_done"}, 64'(busy), 64'd1);
            check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check({tag, "_hi"}, 64'(HI_input), 64'(exp[63:32]));
                check({tag, "_lo"}, 64'(LO_input), 64'(exp[31:0]));
                @(posedge clk); #1;
                check({tag, "_we_off"}, 64'({HI_write_enable, LO_write_enable}), 64'd0);
                check({tag, "_busy_off"}, 64'(busy), 64'd0);
                check({tag, "_hold"}, {HI_input, LO_input}, exp);
            end
        end
    endtask

    initial begin
        int strobes;
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'd0;
        rs_data = '0; rt_data = '0;
        #1;
        check("reset_outputs", {29'b0, busy, HI_write_enable, LO_write_enable, HI_input, LO_input}, 64'd0);
        @(negedge clk); reset = 1'b0;

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_result("multu_max", 32);
        issue(2'd1, 32'hFFFF_FFFD, 32'd5, 1);         wait_result("mult_neg", 32);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1); wait_result("mult_min", 32);
        issue(2'd2, 32'd7, 32'd2, 1);                 wait_result("divu_7_2", 32);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 1);         wait_result("div_m7_2", 32);
        issue(2'd3, 32'd7, 32'hFFFF_FFFE, 1);         wait_result("div_7_m2", 32);
        issue(2'd3, 32'h0000_1234, 32'd0, 1);         wait_result("div_zero", 32);
        issue(2'd3, 32'hFFFF_FF00, 32'd0, 1);         wait_result("div_zero_neg", 32);
        issue(2'd2, 32'h8765_4321, 32'd0, 1);         wait_result("divu_zero", 32);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_result("div_ovf", 32);
        for (int k = 0; k < 4; k++) begin
            issue(2'(k), $urandom, $urandom_range(1, 32'h7FFF_FFFF) ^ 32'(k[1] << 31), 1);
            wait_result("random", 32);
        end

        // a second start while running must not disturb the first operation
        issue(2'd2, 32'd100, 32'd7, 1);
        repeat (4) @(posedge clk);
        @(negedge clk); op = 2'd0; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("busy_ignored_start", 64'(busy), 64'd1);
        wait_result("ignore_start", 27);

        // five frozen cycles mid-run delay the strobe by exactly five edges
        issue(2'd1, 32'h1234_5678, 32'hFEDC_BA98, 1);
        repeat (10) @(posedge clk);
        @(negedge clk); clk_enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); clk_enable = 1'b1;
        wait_result("freeze", 22);

        // asynchronous reset mid-operation discards it
        issue(2'd0, 32'd123, 32'd456, 0);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset", {29'b0, busy, HI_write_enable, LO_write_enable, HI_input, LO_input}, 64'd0);
        #2 reset = 1'b0;
        strobes = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (HI_write_enable || LO_write_enable) strobes++;
        end
        check("no_strobe_after_reset", 64'(strobes), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);

        issue(2'd0, 32'd6, 32'd7, 1); wait_result("multu_6_7", 32);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
